ex_stage: RTL and testbench

EX_STAGE -- requirements
Module: ex_stage

---
 rtl/ex_stage.sv | 147 ++++++++++++++
 tb/tb_ex_stage.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU drive, branch/jump resolution, and a
// single registered output entry handed to MEM through a valid/ready handshake.
module ex_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_rs1_val,
  input  logic [XLEN-1:0] in_rs2_val,
  input  logic [XLEN-1:0] in_imm,
  input  logic [4:0]      in_rs1,
  input  logic [4:0]      in_rs2,
  input  logic [4:0]      in_rd,
  input  logic            in_rd_we,
  input  logic [3:0]      in_alu_op,
  input  logic            in_a_pc,
  input  logic            in_b_imm,
  input  logic            in_branch,
  input  logic [2:0]      in_funct3,
  input  logic            in_jal,
  input  logic            in_jalr,
  input  logic            in_load,
  input  logic            in_store,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [3:0]      alu_op,
  input  logic [XLEN-1:0] alu_res,
  input  logic            wb_we,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_res,
  output logic [XLEN-1:0] out_store_data,
  output logic [4:0]      out_rd,
  output logic            out_rd_we,
  output logic            out_load,
  output logic            out_store,
  output logic            out_redirect,
  output logic [XLEN-1:0] out_redirect_pc
);

  localparam logic [XLEN-1:0] ZERO_C = {XLEN{1'b0}};
  localparam logic [XLEN-1:0] FOUR_C = XLEN'(4);
  localparam logic [XLEN-1:0] MASK_C = {{(XLEN-1){1'b1}}, 1'b0};

  logic [XLEN-1:0] fwd_rs1_s;
  logic [XLEN-1:0] fwd_rs2_s;
  logic [XLEN-1:0] res_s;
  logic [XLEN-1:0] redirect_pc_s;
  logic            redirect_s;
  logic            accept_s;

  // A held non-load result beats writeback; x0 always reads zero.
  function automatic logic [XLEN-1:0] fwd(
    input logic [4:0]      addr,
    input logic [XLEN-1:0] rf_val,
    input logic            held_hit_en,
    input logic [4:0]      held_rd,
    input logic [XLEN-1:0] held_val,
    input logic            wb_en,
    input logic [4:0]      wb_addr,
    input logic [XLEN-1:0] wb_val
  );
    logic [XLEN-1:0] v;
    if (addr == 5'd0) begin
      v = ZERO_C;
    end else if (held_hit_en && (held_rd == addr)) begin
      v = held_val;
    end else if (wb_en && (wb_addr == addr)) begin
      v = wb_val;
    end else begin
      v = rf_val;
    end
    return v;
  endfunction

  function automatic logic br_taken(
    input logic [2:0]      f3,
    input logic [XLEN-1:0] a,
    input logic [XLEN-1:0] b
  );
    logic t;
    case (f3)
      3'b000:  t = (a == b);
      3'b001:  t = (a != b);
      3'b100:  t = ($signed(a) < $signed(b));
      3'b101:  t = ($signed(a) >= $signed(b));
      3'b110:  t = (a < b);
      3'b111:  t = (a >= b);
      default: t = 1'b0;
    endcase
    return t;
  endfunction

  // Handshake, forwarding, ALU operand selection and next-entry values.
  always_comb begin
    in_ready  = !out_valid || out_ready;
    accept_s  = in_valid && in_ready && !flush;
    fwd_rs1_s = fwd(in_rs1, in_rs1_val, out_valid && out_rd_we && !out_load,
                    out_rd, out_res, wb_we, wb_rd, wb_data);
    fwd_rs2_s = fwd(in_rs2, in_rs2_val, out_valid && out_rd_we && !out_load,
                    out_rd, out_res, wb_we, wb_rd, wb_data);
    alu_a     = in_a_pc  ? in_pc  : fwd_rs1_s;
    alu_b     = in_b_imm ? in_imm : fwd_rs2_s;
    alu_op    = in_alu_op;
    res_s     = (in_jal || in_jalr) ? (in_pc + FOUR_C) : alu_res;
    redirect_s    = in_jal || in_jalr || (in_branch && br_taken(in_funct3, fwd_rs1_s, fwd_rs2_s));
    redirect_pc_s = in_jalr ? (alu_res & MASK_C) : (in_pc + in_imm);
  end

  // Output entry register: flush wins, then capture, then drain, else hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid       <= 1'b0;
      out_res         <= ZERO_C;
      out_store_data  <= ZERO_C;
      out_rd          <= 5'd0;
      out_rd_we       <= 1'b0;
      out_load        <= 1'b0;
      out_store       <= 1'b0;
      out_redirect    <= 1'b0;
      out_redirect_pc <= ZERO_C;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept_s) begin
      out_valid       <= 1'b1;
      out_res         <= res_s;
      out_store_data  <= fwd_rs2_s;
      out_rd          <= in_rd;
      out_rd_we       <= in_rd_we;
      out_load        <= in_load;
      out_store       <= in_store;
      out_redirect    <= redirect_s;
      out_redirect_pc <= redirect_pc_s;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= out_valid;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage with a behavioural ALU attached to alu_a/alu_b/alu_op.
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [31:0] in_pc, in_rs1_val, in_rs2_val, in_imm;
  logic [4:0]  in_rs1, in_rs2, in_rd;
  logic        in_rd_we;
  logic [3:0]  in_alu_op;
  logic        in_a_pc, in_b_imm, in_branch;
  logic [2:0]  in_funct3;
  logic        in_jal, in_jalr, in_load, in_store;
  logic [31:0] alu_a, alu_b, alu_res;
  logic [3:0]  alu_op;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        flush;
  logic        out_valid, out_ready;
  logic [31:0] out_res, out_store_data, out_redirect_pc;
  logic [4:0]  out_rd;
  logic        out_rd_we, out_load, out_store, out_redirect;

  int n_checks = 0;
  int n_errs   = 0;

  ex_stage #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val), .in_imm(in_imm),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_rd_we(in_rd_we),
    .in_alu_op(in_alu_op), .in_a_pc(in_a_pc), .in_b_imm(in_b_imm),
    .in_branch(in_branch), .in_funct3(in_funct3), .in_jal(in_jal), .in_jalr(in_jalr),
    .in_load(in_load), .in_store(in_store),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_res(alu_res),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res),
    .out_store_data(out_store_data), .out_rd(out_rd), .out_rd_we(out_rd_we),
    .out_load(out_load), .out_store(out_store), .out_redirect(out_redirect),
    .out_redirect_pc(out_redirect_pc)
  );

  always #5 clk = ~clk;

  // Reference combinational ALU.
  always_comb begin
    case (alu_op)
      4'b0000: alu_res = alu_a + alu_b;
      4'b1000: alu_res = alu_a - alu_b;
      4'b0010: alu_res = {31'd0, $signed(alu_a) < $signed(alu_b)};
      4'b0011: alu_res = {31'd0, alu_a < alu_b};
      4'b0100: alu_res = alu_a ^ alu_b;
      4'b0110: alu_res = alu_a | alu_b;
      4'b0111: alu_res = alu_a & alu_b;
      4'b0001: alu_res = alu_a << alu_b[4:0];
      4'b0101: alu_res = alu_a >> alu_b[4:0];
      4'b1101: alu_res = $unsigned($signed(alu_a) >>> alu_b[4:0]);
      4'b1001: alu_res = alu_b;
      default: alu_res = 32'd0;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic idle();
    in_valid = 1'b0; in_pc = 32'd0; in_rs1_val = 32'd0; in_rs2_val = 32'd0; in_imm = 32'd0;
    in_rs1 = 5'd0; in_rs2 = 5'd0; in_rd = 5'd0; in_rd_we = 1'b0; in_alu_op = 4'b0000;
    in_a_pc = 1'b0; in_b_imm = 1'b0; in_branch = 1'b0; in_funct3 = 3'b000;
    in_jal = 1'b0; in_jalr = 1'b0; in_load = 1'b0; in_store = 1'b0;
    wb_we = 1'b0; wb_rd = 5'd0; wb_data = 32'd0; flush = 1'b0;
  endtask

  task automatic alu_instr(input logic [4:0] rs1, input logic [31:0] v1,
                           input logic [4:0] rs2, input logic [31:0] v2,
                           input logic [31:0] imm, input logic bimm,
                           input logic [4:0] rd, input logic [3:0] op);
    idle();
    in_valid = 1'b1; in_rs1 = rs1; in_rs1_val = v1; in_rs2 = rs2; in_rs2_val = v2;
    in_imm = imm; in_b_imm = bimm; in_rd = rd; in_rd_we = 1'b1; in_alu_op = op;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    out_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    check("rst_valid", out_valid, 32'd0);
    check("rst_res", out_res, 32'd0);
    check("rst_redirect", out_redirect, 32'd0);
    check("rst_in_ready", in_ready, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // add rs1=5 + imm 7
    alu_instr(5'd2, 32'd5, 5'd0, 32'd0, 32'd7, 1'b1, 5'd3, 4'b0000);
    #1;
    check("add_alu_op", alu_op, 32'd0);
    check("add_alu_b", alu_b, 32'd7);
    step();
    check("add_valid", out_valid, 32'd1);
    check("add_res", out_res, 32'd12);
    check("add_rd", out_rd, 32'd3);

    // addi x1 = x0 + 3 (x0 reads 0 even with a stale rf value)
    alu_instr(5'd0, 32'd123, 5'd0, 32'd0, 32'd3, 1'b1, 5'd1, 4'b0000);
    #1;
    check("x0_zero", alu_a, 32'd0);
    step();
    check("addi_res", out_res, 32'd3);
    alu_instr(5'd1, 32'd0, 5'd1, 32'd0, 32'd0, 1'b0, 5'd2, 4'b0000);
    #1;
    check("fwd_held_a", alu_a, 32'd3);
    step();
    check("fwd_held_res", out_res, 32'd6);

    // held rd=4, writeback supplies x1=9
    alu_instr(5'd0, 32'd0, 5'd0, 32'd0, 32'd1, 1'b1, 5'd4, 4'b0000);
    step();
    alu_instr(5'd1, 32'd0, 5'd1, 32'd0, 32'd0, 1'b0, 5'd2, 4'b0000);
    wb_we = 1'b1; wb_rd = 5'd1; wb_data = 32'd9;
    step();
    check("fwd_wb_res", out_res, 32'd18);
    check("fwd_wb_store", out_store_data, 32'd9);

    // held x1=5 beats writeback x1=9
    alu_instr(5'd0, 32'd0, 5'd0, 32'd0, 32'd5, 1'b1, 5'd1, 4'b0000);
    step();
    alu_instr(5'd1, 32'd0, 5'd1, 32'd0, 32'd0, 1'b0, 5'd2, 4'b0000);
    wb_we = 1'b1; wb_rd = 5'd1; wb_data = 32'd9;
    step();
    check("fwd_prio_res", out_res, 32'd10);

    // held load to x1 must not forward
    alu_instr(5'd0, 32'd0, 5'd0, 32'd0, 32'h50, 1'b1, 5'd1, 4'b0000);
    in_load = 1'b1;
    step();
    check("load_flag", out_load, 32'd1);
    alu_instr(5'd1, 32'd7, 5'd0, 32'd0, 32'd0, 1'b0, 5'd5, 4'b0000);
    #1;
    check("load_nofwd", alu_a, 32'd7);
    step();
    check("load_nofwd_res", out_res, 32'd7);

    // stall three cycles, then release
    out_ready = 1'b0;
    alu_instr(5'd0, 32'd0, 5'd0, 32'd0, 32'd100, 1'b1, 5'd6, 4'b0000);
    #1;
    check("stall_in_ready", in_ready, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_res", out_res, 32'd7);
      check("stall_rd", out_rd, 32'd5);
      check("stall_valid", out_valid, 32'd1);
    end
    out_ready = 1'b1;
    #1;
    check("release_in_ready", in_ready, 32'd1);
    step();
    check("release_res", out_res, 32'd100);
    check("release_valid", out_valid, 32'd1);
    idle();
    step();
    check("drain_valid", out_valid, 32'd0);

    // blt -1 < 1 taken; bltu not taken; 010 never taken
    idle();
    in_valid = 1'b1; in_branch = 1'b1; in_funct3 = 3'b100; in_pc = 32'h100; in_imm = 32'h20;
    in_rs1 = 5'd5; in_rs1_val = 32'hFFFF_FFFF; in_rs2 = 5'd6; in_rs2_val = 32'd1;
    step();
    check("blt_redirect", out_redirect, 32'd1);
    check("blt_pc", out_redirect_pc, 32'h120);
    in_funct3 = 3'b110;
    step();
    check("bltu_redirect", out_redirect, 32'd0);
    in_funct3 = 3'b010; in_rs2_val = 32'hFFFF_FFFF;
    step();
    check("f3_010_redirect", out_redirect, 32'd0);
    in_funct3 = 3'b000;
    step();
    check("beq_redirect", out_redirect, 32'd1);

    // jalr x? = 0x1001 + 2 -> target 0x1002, link 0x44
    idle();
    in_valid = 1'b1; in_jalr = 1'b1; in_pc = 32'h40; in_imm = 32'd2; in_b_imm = 1'b1;
    in_rs1 = 5'd7; in_rs1_val = 32'h1001; in_rd = 5'd1; in_rd_we = 1'b1;
    step();
    check("jalr_res", out_res, 32'h44);
    check("jalr_pc", out_redirect_pc, 32'h1002);
    check("jalr_redirect", out_redirect, 32'd1);
    flush = 1'b1;
    step();
    check("flush_valid", out_valid, 32'd0);

    // jal wrap at top of address space
    idle();
    in_valid = 1'b1; in_jal = 1'b1; in_pc = 32'hFFFF_FFFC; in_imm = 32'd8;
    step();
    check("wrap_link", out_res, 32'd0);
    check("wrap_target", out_redirect_pc, 32'd4);

    // reset while stalled with a valid entry
    out_ready = 1'b0;
    idle();
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_valid", out_valid, 32'd0);
    check("rst_mid_res", out_res, 32'd0);
    check("rst_mid_redirect", out_redirect, 32'd0);
    check("rst_mid_pc", out_redirect_pc, 32'd0);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    alu_instr(5'd2, 32'd40, 5'd0, 32'd0, 32'd2, 1'b1, 5'd3, 4'b1000);
    step();
    check("post_rst_valid", out_valid, 32'd1);
    check("post_rst_sub", out_res, 32'd38);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
